multiport_reg_file: RTL and testbench
=====================================

# multiport_reg_file

Parametrised general-purpose register file for the RISC-V core: configurable data width, depth, read-port count and write-port count. It adds optional write-to-read bypass, a hardwired zero entry, deterministic write-port priority and a sequential post-reset clear engine with a `ready` indication. It replaces the fixed 2-read/1-write, 32x32 register array between decode (read) and writeback (write).

## Interface
- `DATA_W`, 32: width of each entry in bits.
- `ADDR_W`, 5: address width; DEPTH = 2**ADDR_W entries.
- `NUM_RD`, 2: number of asynchronous read ports (1..4).
- `NUM_WR`, 1: number of synchronous write ports (1..2).
- `ZERO_REG`, 1: 1 means entry 0 reads as 0 and ignores writes.
- `BYPASS`, 0: 1 means a same-cycle write is forwarded to matching read ports.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-low (asserted when 0, sampled on the `clk` rising edge).
- `we`  in  NUM_WR  per-port write enable.
- `wa`  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W].
- `wd`  in  NUM_WR*DATA_W  write data, port k at bits [k*DATA_W +: DATA_W].
- `ra`  in  NUM_RD*ADDR_W  read addresses, packed as `wa`.
- `rd`  out  NUM_RD*DATA_W  read data, packed as `wd`.
- `ready`  out  1  high once the clear sequence has completed; reset value 0.
- `wr_conflict`  out  1  registered pulse: previous cycle had two enabled writes to the same address; reset value 0.

## Operation
- Init FSM states: CLEAR, READY.
  - While `rst`=0: state is CLEAR, clear pointer is 0, `ready`=0, `wr_conflict`=0.
  - In CLEAR, each cycle writes 0 to entry[ptr] and increments ptr.
  - When ptr == DEPTH-1 is written, the FSM moves to READY next cycle.
  - READY is held until the next reset. A reset mid-clear or mid-operation restarts at ptr 0.
- Writes:
  - Accepted only in READY. Port writes in CLEAR are dropped silently.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Write conflict: if two enabled ports target the same address, the higher port index wins. `wr_conflict` goes high the following cycle for one cycle. This applies even when the address is 0 with ZERO_REG=1.
- Reads:
  - Combinational from `ra`.
  - Address 0 returns 0 when ZERO_REG=1.
  - In CLEAR, all read ports return 0.
- Bypass (BYPASS=1, READY only): if a read address matches an enabled, non-dropped write address in the same cycle, `rd` returns that write's `wd`. If several writes match, the highest port index wins.
- BYPASS=0: a read of the address being written returns the old value until after the edge.
- Width rules: no sign or width conversion. Out-of-range addresses cannot occur because DEPTH = 2**ADDR_W.

## Timing
- Write latency: data written at edge N is visible on a non-bypassed read after edge N, i.e. in cycle N+1. With BYPASS=1 it is visible in cycle N.
- Read latency: 0 cycles (combinational).
- Clear duration: `ready` rises exactly DEPTH cycles after the first edge at which `rst`=1 (32 cycles at defaults).
- `wr_conflict`: 1-cycle registered delay relative to the offending write cycle.
- `ready` and `wr_conflict` are registered outputs; `rd` is combinational.

## Structure
- Shared package `rf_pkg`:
  - init state enum `rf_state_t` {RF_CLEAR, RF_READY};
  - helper localparams `RF_DEPTH(ADDR_W)` and the packed-slice width macros;
  - reused by the future FP register file.
- Sub-module `rf_init_ctrl`:
  - contains the CLEAR/READY FSM and clear pointer;
  - outputs `clr_en`, `clr_addr`, `ready`.
- The top level contains the storage array (distributed RAM style), write-port priority mux, bypass mux and conflict detector.

## Test plan
- Reset and clear: hold `rst`=0 for 3 cycles, then release → `ready`=0 for 32 cycles and 1 on cycle 33; all 32 entries read 0.
- Basic write/read (defaults): write 0xDEADBEEF to x5, then read x5 on both ports next cycle → 0xDEADBEEF on both. Write 0x1234 to x0 → x0 reads 0.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to x7 while `ra` port 1 = 7 → `rd` port 1 = 0xA5A5A5A5 in the same cycle. With BYPASS=0 → old value 0.
- Dual-write conflict: NUM_WR=2, port0 writes 0x11 and port1 writes 0x22 to x9 → x9 = 0x22 next cycle; `wr_conflict`=1 for exactly that cycle.
- Writes during clear: issue a write of 0xFF to x3 at clear cycle 10 → ignored; after `ready`, x3 = 0.
- Reset mid-operation: fill x1..x31 with nonzero data, pulse `rst`=0 for 1 cycle → `ready` drops, 32-cycle clear reruns, all entries read 0 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: init FSM states and sizing helpers.
// Also meant for the floating-point register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Number of entries addressed by an address of the given width.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Width of a flat bus that packs `ports` fields of `width` bits each.
  function automatic int rf_bus_w(input int ports, input int width);
    return ports * width;
  endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Port bundle for multiport_reg_file: write ports, read ports and status.
// The master side drives addresses and write data, and the slave side returns read data.
interface multiport_reg_file_if
  import rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);

  logic [NUM_WR-1:0]                      we;
  logic [rf_bus_w(NUM_WR, ADDR_W)-1:0]    wa;
  logic [rf_bus_w(NUM_WR, DATA_W)-1:0]    wd;
  logic [rf_bus_w(NUM_RD, ADDR_W)-1:0]    ra;
  logic [rf_bus_w(NUM_RD, DATA_W)-1:0]    rd;
  logic                                   ready;
  logic                                   wr_conflict;

  modport master (
    output we, wa, wd, ra,
    input  rd, ready, wr_conflict
  );

  modport slave (
    input  we, wa, wd, ra,
    output rd, ready, wr_conflict
  );

endinterface

// File: rtl/rf_init_ctrl.sv
// Post-reset clear sequencer: sweeps every entry to zero once, then holds READY.
// The ready output is registered alongside the state so it never glitches.
module rf_init_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_t         state;
  logic [ADDR_W-1:0] ptr;

  // The last entry is written on the same edge that moves the FSM to READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RF_CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == {ADDR_W{1'b1}}) begin
            state <= RF_READY;
            ready <= 1'b1;
          end
        end
        RF_READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= RF_CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en   = (state == RF_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised GPR file: async read ports, prioritised sync write ports,
// optional zero register and write-to-read bypass, and a post-reset clear.
module multiport_reg_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input logic                 clk,
  input logic                 rst,
  multiport_reg_file_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0]                   mem [DEPTH];
  logic                                clr_en;
  logic [ADDR_W-1:0]                   clr_addr;
  logic                                ready_q;
  logic                                wr_conflict_q;
  logic                                conflict_now;
  logic [NUM_WR-1:0]                   wr_ok;
  logic [ADDR_W-1:0]                   wa_arr [NUM_WR];
  logic [DATA_W-1:0]                   wd_arr [NUM_WR];
  logic [ADDR_W-1:0]                   ra_arr [NUM_RD];
  logic [DATA_W-1:0]                   rd_arr [NUM_RD];
  logic [rf_bus_w(NUM_RD, DATA_W)-1:0] rd_flat;

  rf_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready_q)
  );

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wa_arr[k] = bus.wa[k*ADDR_W +: ADDR_W];
    assign wd_arr[k] = bus.wd[k*DATA_W +: DATA_W];
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_unpack
    assign ra_arr[r] = bus.ra[r*ADDR_W +: ADDR_W];
  end

  // A write only takes effect once the clear sweep is done and it does not target the zero register.
  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_ok[k] = bus.we[k] && !clr_en &&
                 !((ZERO_REG != 0) && (wa_arr[k] == '0));
    end
  end

  // Conflicts are judged on raw enables, so colliding writes to x0 still flag.
  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (bus.we[i] && bus.we[j] && (wa_arr[i] == wa_arr[j])) begin
          conflict_now = 1'b1;
        end
      end
    end
  end

  // Ascending port order lets the highest-index writer land last and win.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) begin
          mem[wa_arr[k]] <= wd_arr[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= conflict_now;
    end
  end

  // Read path: masked to zero during clear and for x0, then optionally forwarded from a same-cycle write.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_arr[r] = mem[ra_arr[r]];
      if (clr_en || ((ZERO_REG != 0) && (ra_arr[r] == '0))) begin
        rd_arr[r] = '0;
      end else if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k] && (wa_arr[k] == ra_arr[r])) begin
            rd_arr[r] = wd_arr[k];
          end
        end
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_flat[r*DATA_W +: DATA_W] = rd_arr[r];
    end
  end

  assign bus.rd          = rd_flat;
  assign bus.ready       = ready_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed self-checking bench: a default-configured instance (a) and a
// dual-write bypassing instance (b) share clock and reset.
module tb_multiport_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multiport_reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1)) ifa ();
  multiport_reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) ifb ();

  multiport_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  multiport_reg_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  function automatic logic [31:0] rd_a(input int p);
    return ifa.rd[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_b(input int p);
    return ifb.rd[p*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.we = '0; ifa.wa = '0; ifa.wd = '0; ifa.ra = '0;
    ifb.we = '0; ifb.wa = '0; ifb.wd = '0; ifb.ra = '0;
  endtask

  // Reset, clear sweep timing, a write dropped at clear cycle 10, all entries zero afterwards.
  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (ifa.ready !== 1'b0) $display("[TB] FAIL reset_ready_a: got %b expected 0", ifa.ready); else passed++;
    checks++; if (ifb.ready !== 1'b0) $display("[TB] FAIL reset_ready_b: got %b expected 0", ifb.ready); else passed++;
    checks++; if (ifa.wr_conflict !== 1'b0) $display("[TB] FAIL reset_conflict_a: got %b expected 0", ifa.wr_conflict); else passed++;
    checks++; if (ifb.wr_conflict !== 1'b0) $display("[TB] FAIL reset_conflict_b: got %b expected 0", ifb.wr_conflict); else passed++;
    checks++; if (rd_a(0) !== 32'h0) $display("[TB] FAIL reset_rd_a: got %h expected 0", rd_a(0)); else passed++;
    rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++;
      if (ifa.ready !== (i == 32)) $display("[TB] FAIL clear_ready_a cycle %0d: got %b expected %b", i, ifa.ready, (i == 32));
      else passed++;
      if (i == 9) begin
        ifa.we = 1'b1; ifa.wa = 5'd3; ifa.wd = 32'hFF;
        ifb.we = 2'b01; ifb.wa = {5'd0, 5'd3}; ifb.wd = {32'h0, 32'hFF};
        ifa.ra = {5'd3, 5'd3};
        #1;
        checks++; if (rd_a(0) !== 32'h0) $display("[TB] FAIL clear_read_zero: got %h expected 0", rd_a(0)); else passed++;
      end
      if (i == 10) idle_all();
      if (i >= 31) begin
        checks++;
        if (ifb.ready !== (i == 32)) $display("[TB] FAIL clear_ready_b cycle %0d: got %b expected %b", i, ifb.ready, (i == 32));
        else passed++;
      end
    end
    for (int e = 0; e < 32; e++) begin
      ifa.ra = {5'(31 - e), 5'(e)};
      ifb.ra = {5'(31 - e), 5'(e)};
      #1;
      checks++; if (rd_a(0) !== 32'h0 || rd_a(1) !== 32'h0) $display("[TB] FAIL cleared_a x%0d: got %h/%h expected 0", e, rd_a(0), rd_a(1)); else passed++;
      checks++; if (rd_b(0) !== 32'h0 || rd_b(1) !== 32'h0) $display("[TB] FAIL cleared_b x%0d: got %h/%h expected 0", e, rd_b(0), rd_b(1)); else passed++;
    end
  endtask

  // Plain write then read on both ports; x0 ignores writes.
  task automatic test_basic_write();
    idle_all();
    ifa.we = 1'b1; ifa.wa = 5'd5; ifa.wd = 32'hDEADBEEF;
    ifa.ra = {5'd5, 5'd5};
    tick();
    ifa.we = 1'b0;
    #1;
    checks++; if (rd_a(0) !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd0: got %h expected deadbeef", rd_a(0)); else passed++;
    checks++; if (rd_a(1) !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd1: got %h expected deadbeef", rd_a(1)); else passed++;
    ifa.we = 1'b1; ifa.wa = 5'd0; ifa.wd = 32'h1234;
    ifa.ra = {5'd5, 5'd0};
    tick();
    ifa.we = 1'b0;
    #1;
    checks++; if (rd_a(0) !== 32'h0) $display("[TB] FAIL zero_reg: got %h expected 0", rd_a(0)); else passed++;
    checks++; if (rd_a(1) !== 32'hDEADBEEF) $display("[TB] FAIL x5_kept: got %h expected deadbeef", rd_a(1)); else passed++;
  endtask

  // Same-cycle forwarding on b, old value on a, no forwarding of x0 writes.
  task automatic test_bypass();
    idle_all();
    ifa.we = 1'b1; ifa.wa = 5'd7; ifa.wd = 32'hA5A5A5A5; ifa.ra = {5'd7, 5'd0};
    ifb.we = 2'b01; ifb.wa = {5'd0, 5'd7}; ifb.wd = {32'h0, 32'hA5A5A5A5}; ifb.ra = {5'd7, 5'd0};
    #1;
    checks++; if (rd_b(1) !== 32'hA5A5A5A5) $display("[TB] FAIL bypass_b: got %h expected a5a5a5a5", rd_b(1)); else passed++;
    checks++; if (rd_a(1) !== 32'h0) $display("[TB] FAIL nobypass_a_old: got %h expected 0", rd_a(1)); else passed++;
    tick();
    idle_all();
    ifa.ra = {5'd7, 5'd0};
    #1;
    checks++; if (rd_a(1) !== 32'hA5A5A5A5) $display("[TB] FAIL nobypass_a_after: got %h expected a5a5a5a5", rd_a(1)); else passed++;
    ifb.we = 2'b10; ifb.wa = {5'd0, 5'd0}; ifb.wd = {32'hCAFE, 32'h0}; ifb.ra = {5'd0, 5'd0};
    #1;
    checks++; if (rd_b(0) !== 32'h0) $display("[TB] FAIL bypass_x0: got %h expected 0", rd_b(0)); else passed++;
    ifb.we = 2'b11; ifb.wa = {5'd12, 5'd12}; ifb.wd = {32'hBBBB, 32'hAAAA}; ifb.ra = {5'd0, 5'd12};
    #1;
    checks++; if (rd_b(0) !== 32'hBBBB) $display("[TB] FAIL bypass_prio: got %h expected 0000bbbb", rd_b(0)); else passed++;
    tick();
    idle_all();
    tick();
  endtask

  // Dual writes: colliding, disjoint, and colliding on x0.
  task automatic test_conflict();
    idle_all();
    ifb.we = 2'b11; ifb.wa = {5'd9, 5'd9}; ifb.wd = {32'h22, 32'h11}; ifb.ra = {5'd0, 5'd9};
    #1;
    checks++; if (ifb.wr_conflict !== 1'b0) $display("[TB] FAIL conflict_early: got %b expected 0", ifb.wr_conflict); else passed++;
    tick();
    idle_all();
    ifb.ra = {5'd0, 5'd9};
    #1;
    checks++; if (ifb.wr_conflict !== 1'b1) $display("[TB] FAIL conflict_pulse: got %b expected 1", ifb.wr_conflict); else passed++;
    checks++; if (rd_b(0) !== 32'h22) $display("[TB] FAIL conflict_winner: got %h expected 00000022", rd_b(0)); else passed++;
    ifb.we = 2'b11; ifb.wa = {5'd11, 5'd10}; ifb.wd = {32'h44, 32'h33};
    tick();
    idle_all();
    ifb.ra = {5'd11, 5'd10};
    #1;
    checks++; if (ifb.wr_conflict !== 1'b0) $display("[TB] FAIL conflict_clear: got %b expected 0", ifb.wr_conflict); else passed++;
    checks++; if (rd_b(0) !== 32'h33 || rd_b(1) !== 32'h44) $display("[TB] FAIL dual_disjoint: got %h/%h expected 33/44", rd_b(0), rd_b(1)); else passed++;
    ifb.we = 2'b11; ifb.wa = {5'd0, 5'd0}; ifb.wd = {32'h66, 32'h55};
    tick();
    idle_all();
    #1;
    checks++; if (ifb.wr_conflict !== 1'b1) $display("[TB] FAIL conflict_x0: got %b expected 1", ifb.wr_conflict); else passed++;
    checks++; if (rd_b(0) !== 32'h0) $display("[TB] FAIL x0_after_conflict: got %h expected 0", rd_b(0)); else passed++;
    tick();
    checks++; if (ifb.wr_conflict !== 1'b0) $display("[TB] FAIL conflict_single: got %b expected 0", ifb.wr_conflict); else passed++;
  endtask

  // Fill, pulse reset for one cycle, and confirm a full clear reruns.
  task automatic test_reset_mid_op();
    idle_all();
    for (int i = 1; i < 32; i++) begin
      ifa.we = 1'b1; ifa.wa = 5'(i); ifa.wd = 32'h01010101 * i;
      ifb.we = 2'b10; ifb.wa = {5'(i), 5'd0}; ifb.wd = {32'h80000000 | i, 32'h0};
      tick();
    end
    idle_all();
    ifa.ra = {5'd31, 5'd5};
    ifb.ra = {5'd0, 5'd17};
    #1;
    checks++; if (rd_a(0) !== 32'h05050505 || rd_a(1) !== 32'h1F1F1F1F) $display("[TB] FAIL fill_a: got %h/%h expected 05050505/1f1f1f1f", rd_a(0), rd_a(1)); else passed++;
    checks++; if (rd_b(0) !== 32'h80000011) $display("[TB] FAIL fill_b: got %h expected 80000011", rd_b(0)); else passed++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (ifa.ready !== 1'b0 || ifb.ready !== 1'b0) $display("[TB] FAIL rerst_ready: got %b/%b expected 0/0", ifa.ready, ifb.ready); else passed++;
    checks++; if (rd_a(0) !== 32'h0) $display("[TB] FAIL rerst_read_masked: got %h expected 0", rd_a(0)); else passed++;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i >= 31) begin
        checks++;
        if (ifa.ready !== (i == 32) || ifb.ready !== (i == 32))
          $display("[TB] FAIL rerst_ready cycle %0d: got %b/%b expected %b", i, ifa.ready, ifb.ready, (i == 32));
        else passed++;
      end
    end
    for (int e = 0; e < 32; e++) begin
      ifa.ra = {5'(e), 5'(e)};
      ifb.ra = {5'(e), 5'(e)};
      #1;
      checks++;
      if (rd_a(0) !== 32'h0 || rd_b(1) !== 32'h0) $display("[TB] FAIL rerst_cleared x%0d: got %h/%h expected 0", e, rd_a(0), rd_b(1));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bypass();
    test_conflict();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
